// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the round-robin ALU scheduler.
package alu_pkg;
    localparam int         OPW    = 3;
    localparam int         N_IO   = 8;
    localparam logic [2:0] OP_MAX = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_rr_sched_if.sv
// Request/response bundle between client blocks and the ALU scheduler.
interface alu_rr_sched_if #(
    parameter int NREQ = 4,
    parameter int nIO  = 8,
    parameter int OPW  = 3,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*nIO-1:0] req_a;
    logic [NREQ*nIO-1:0] req_b;
    logic [NREQ*OPW-1:0] req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [nIO-1:0]      rsp_z;
    logic                rsp_ov;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_ov
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_z, rsp_ov
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);
    logic          found_s;
    logic [PW-1:0] slot_s;

    // Walk the N slots starting at ptr; the first valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        slot_s    = '0;
        for (int k = 0; k < N; k++) begin
            slot_s = PW'((int'(ptr) + k) % N);
            if (en && !found_s && req[slot_s]) begin
                found_s        = 1'b1;
                grant[slot_s]  = 1'b1;
                grant_idx      = slot_s;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/alu_rr_sched.sv
// Shares one combinational ALU among NREQ requesters with round-robin
// arbitration and a tagged, back-pressurable response channel.
module alu_rr_sched #(
    parameter int NREQ = 4,
    parameter int nIO  = alu_pkg::N_IO,
    parameter int OPW  = alu_pkg::OPW,
    parameter int IDW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_rr_sched_if.slave    bus,
    output logic [nIO-1:0]   alu_a,
    output logic [nIO-1:0]   alu_b,
    output logic [OPW-1:0]   alu_op,
    input  logic [nIO-1:0]   alu_z,
    input  logic             alu_ov,
    output logic             busy,
    output logic [15:0]      op_count
);
    import alu_pkg::*;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [IDW-1:0]  id_q;
    logic [nIO-1:0]  alu_a_q;
    logic [nIO-1:0]  alu_b_q;
    logic [OPW-1:0]  alu_op_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [nIO-1:0]  rsp_z_q;
    logic            rsp_ov_q;
    logic [15:0]     op_count_q;

    logic [NREQ-1:0] grant_s;
    logic [PW-1:0]   grant_idx_s;
    logic            grant_any_s;
    logic [nIO-1:0]  a_lane_s  [NREQ];
    logic [nIO-1:0]  b_lane_s  [NREQ];
    logic [OPW-1:0]  op_lane_s [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_lane_s[i]  = bus.req_a[i*nIO +: nIO];
        assign b_lane_s[i]  = bus.req_b[i*nIO +: nIO];
        assign op_lane_s[i] = bus.req_op[i*OPW +: OPW];
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .en        (state_q == IDLE),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Ready is only ever offered to the arbiter's pick, and only while idle.
    assign bus.req_ready = grant_s;
    assign grant_any_s   = |grant_s;

    // Scheduler FSM: grant in IDLE, sample the ALU in EXEC, hand off in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            rsp_ov_q    <= 1'b0;
            op_count_q  <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any_s) begin
                        alu_a_q  <= a_lane_s[grant_idx_s];
                        alu_b_q  <= b_lane_s[grant_idx_s];
                        alu_op_q <= op_lane_s[grant_idx_s];
                        id_q     <= IDW'(grant_idx_s);
                        ptr_q    <= (grant_idx_s == PW'(NREQ - 1)) ? '0 : grant_idx_s + 1'b1;
                        state_q  <= EXEC;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_z_q     <= alu_z;
                    rsp_ov_q    <= alu_ov;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    // The exit cycle deliberately skips arbitration; a grant waits for IDLE.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 16'd1;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_op        = alu_op_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_ov    = rsp_ov_q;
    assign busy          = (state_q != IDLE);
    assign op_count      = op_count_q;
endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: directed and random traffic checked against a
// transaction-level reference of the arbitration, latency and ALU result.
module tb_alu_rr_sched;
    import alu_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 8;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  alu_a, alu_b, alu_z;
    logic [2:0]  alu_op;
    logic        alu_ov;
    logic        busy;
    logic [15:0] op_count;

    alu_rr_sched_if #(.NREQ(NREQ), .nIO(W), .OPW(3), .IDW(2)) bus ();

    alu_rr_sched #(.NREQ(NREQ), .nIO(W), .OPW(3), .IDW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_z    (alu_z),
        .alu_ov   (alu_ov),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Gate-style ALU attached to the scheduler.
    always_comb begin
        alu_z  = 8'h00;
        alu_ov = 1'b0;
        case (alu_op)
            3'd0: begin alu_z = alu_a + alu_b; alu_ov = (alu_a[7] == alu_b[7]) && (alu_z[7] != alu_a[7]); end
            3'd1: begin alu_z = alu_a - alu_b; alu_ov = (alu_a[7] != alu_b[7]) && (alu_z[7] != alu_a[7]); end
            3'd2: alu_z = alu_a;
            3'd3: alu_z = alu_a & alu_b;
            3'd4: alu_z = alu_a | alu_b;
            3'd5: alu_z = alu_a ^ alu_b;
            3'd6: alu_z = ~alu_a;
            3'd7: alu_z = alu_b;
            default: alu_z = 8'h00;
        endcase
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    req_t        pend [NREQ][$];
    int          grant_log[$];
    int          ptr_m, acc_cyc, cyc, exp_id, stall_left, used;
    bit          inflight, rand_ready;
    logic [15:0] count_m;
    logic [7:0]  exp_z;
    logic        exp_ov;

    // Reference ALU using integer arithmetic: overflow = result outside signed 8-bit range.
    function automatic logic [8:0] ref_alu(input req_t r);
        int sa, sb, s;
        sa = int'($signed(r.a));
        sb = int'($signed(r.b));
        case (r.op)
            3'd0: s = sa + sb;
            3'd1: s = sa - sb;
            3'd2: s = sa;
            3'd3: s = int'($signed(r.a & r.b));
            3'd4: s = int'($signed(r.a | r.b));
            3'd5: s = int'($signed(r.a ^ r.b));
            3'd6: s = int'($signed(~r.a));
            default: s = sb;
        endcase
        return {(s > 127 || s < -128), s[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit work_left();
        bit w = inflight;
        for (int i = 0; i < NREQ; i++) if (pend[i].size() > 0) w = 1'b1;
        return w;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i].size() > 0) begin
                bus.req_valid[i]      = 1'b1;
                bus.req_a[i*W +: W]   = pend[i][0].a;
                bus.req_b[i*W +: W]   = pend[i][0].b;
                bus.req_op[i*3 +: 3]  = pend[i][0].op;
            end else begin
                bus.req_valid[i]      = 1'b0;
                bus.req_a[i*W +: W]   = 8'h00;
                bus.req_b[i*W +: W]   = 8'h00;
                bus.req_op[i*3 +: 3]  = 3'd0;
            end
        end
    endtask

    // One clock of traffic: drive, compare against the model, advance the model.
    task automatic cycle();
        int         g;
        bit         exp_rv;
        logic [3:0] exp_ready;
        logic [8:0] res;
        req_t       item;
        drive_reqs();
        exp_rv = inflight && (cyc >= acc_cyc + 2);
        if (exp_rv && stall_left > 0) begin
            bus.rsp_ready = 1'b0;
            stall_left--;
        end else begin
            bus.rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        #1;
        g = -1;
        if (!inflight)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && pend[(ptr_m + k) % NREQ].size() > 0) g = (ptr_m + k) % NREQ;
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
        check("req_ready", bus.req_ready, exp_ready);
        check("busy", busy, inflight);
        check("rsp_valid", bus.rsp_valid, exp_rv);
        check("op_count", op_count, count_m);
        if (exp_rv) begin
            check("rsp_id", bus.rsp_id, exp_id);
            check("rsp_z", bus.rsp_z, exp_z);
            check("rsp_ov", bus.rsp_ov, exp_ov);
            if (bus.rsp_ready) begin
                inflight = 1'b0;
                count_m  = count_m + 16'd1;
            end
        end
        if (g >= 0) begin
            item     = pend[g].pop_front();
            res      = ref_alu(item);
            exp_z    = res[7:0];
            exp_ov   = res[8];
            exp_id   = g;
            inflight = 1'b1;
            acc_cyc  = cyc;
            ptr_m    = (g + 1) % NREQ;
            grant_log.push_back(g);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int max_cyc, output int n);
        n = 0;
        while (work_left() && n < max_cyc) begin
            cycle();
            n++;
        end
        check("drain_timeout", work_left(), 1'b0);
    endtask

    task automatic model_reset();
        ptr_m    = 0;
        inflight = 1'b0;
        count_m  = 16'd0;
        grant_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) pend[i].delete();
        drive_reqs();
        bus.rsp_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_op_count", op_count, 16'd0);
        rst_n = 1'b1;
    endtask

    task automatic push(input int r, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_t t;
        t.a = a; t.b = b; t.op = op;
        pend[r].push_back(t);
    endtask

    initial begin
        int issued, guard;
        clk = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        bus.rsp_ready = 1'b0;
        cyc = 0; acc_cyc = 0; stall_left = 0; rand_ready = 1'b0;
        exp_id = 0; exp_z = 8'h00; exp_ov = 1'b0;
        #2;
        check("rst_async_rsp_z", bus.rsp_z, 8'h00);
        do_reset();

        // Single op: A=5, B=-3, pass-A opcode.
        push(0, 8'sd5, -8'sd3, OP_MAX);
        run_until_idle(20, used);
        check("single_cycles", used, 3);
        check("single_count", op_count, 16'd1);

        // All four valid from reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) push(i, 8'(i), 8'hFF, OP_MAX);
        run_until_idle(40, used);
        check("all4_cycles", used, 12);
        check("all4_n", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) check("all4_order", grant_log[i], i);

        // Backpressure: response held five cycles while others wait.
        stall_left = 5;
        push(2, 8'h7F, 8'h01, 3'd0);
        push(0, 8'h80, 8'h01, 3'd1);
        push(1, 8'h3C, 8'hA5, 3'd5);
        run_until_idle(60, used);
        check("bp_cycles", used, 14);

        // Fairness between requesters 1 and 3.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            push(1, 8'($urandom), 8'($urandom), 3'($urandom));
            push(3, 8'($urandom), 8'($urandom), 3'($urandom));
        end
        run_until_idle(200, used);
        for (int i = 0; i < 20; i++) check("fair_id", grant_log[i], (i % 2 == 0) ? 1 : 3);

        // Random traffic with random response back-pressure.
        rand_ready = 1'b1;
        issued = 0;
        guard  = 0;
        while ((issued < 150 || work_left()) && guard < 5000) begin
            if (issued < 150 && $urandom_range(0, 2) == 0) begin
                int r = $urandom_range(0, NREQ - 1);
                if (pend[r].size() < 3) begin
                    push(r, 8'($urandom), 8'($urandom), 3'($urandom));
                    issued++;
                end
            end
            cycle();
            guard++;
        end
        check("rand_done", guard < 5000, 1'b1);
        rand_ready = 1'b0;

        // Reset asserted while an op sits in EXEC.
        for (int i = 0; i < NREQ; i++) push(i, 8'h5A, 8'hC3, 3'd4);
        cycle();
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_alu_a", alu_a, 8'h00);
        check("mid_alu_b", alu_b, 8'h00);
        check("mid_alu_op", alu_op, 3'd0);
        check("mid_rsp_valid", bus.rsp_valid, 1'b0);
        check("mid_rsp_id", bus.rsp_id, 2'd0);
        check("mid_rsp_z", bus.rsp_z, 8'h00);
        check("mid_rsp_ov", bus.rsp_ov, 1'b0);
        check("mid_busy0", busy, 1'b0);
        check("mid_op_count", op_count, 16'd0);
        model_reset();
        push(0, 8'h11, 8'h22, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_until_idle(60, used);
        check("mid_first_grant", grant_log[0], 0);

        // op_count wrap from a preloaded value.
        force dut.op_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.op_count_q;
        count_m = 16'hFFFE;
        for (int i = 0; i < 3; i++) push(2, 8'(i + 1), 8'h01, 3'd0);
        run_until_idle(30, used);
        check("wrap_count", op_count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one combinational ALU among NREQ requesters.
- Each requester presents signed operands A/B and a 3-bit opcode over a valid/ready handshake.
- The scheduler grants one requester, drives the ALU from registered operands, captures Z/OV, and returns the result on a tagged response channel.
- Sits between client blocks and the single ALU instance (A, B, OP in; Z, OV out).

Parameters:
- NREQ, 4, number of requesters (2..8).
- nIO, 8, ALU data width (signed two's complement).
- OPW, 3, opcode width; opcodes are opaque and passed through unmodified.
- IDW, 2, response tag width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*nIO  operand A, requester i at bits [i*nIO +: nIO].
- req_b  in  NREQ*nIO  operand B, same packing as req_a.
- req_op  in  NREQ*OPW  opcode, requester i at bits [i*OPW +: OPW].
- alu_a  out  nIO  to ALU A.
- alu_b  out  nIO  to ALU B.
- alu_op  out  OPW  to ALU OP.
- alu_z  in  nIO  from ALU Z; combinational from alu_a/alu_b/alu_op.
- alu_ov  in  1  from ALU OV.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  index of the requester that issued the operation.
- rsp_z  out  nIO  result.
- rsp_ov  out  1  overflow flag.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed responses; wraps modulo 2**16.

Behaviour:
- Reset (async assert, sync deassert use):
  - state=IDLE; rr pointer=0.
  - alu_a/alu_b/alu_op=0; rsp_valid=0; rsp_id=0; rsp_z=0; rsp_ov=0; op_count=0; busy=0.
  - Reset mid-operation discards the in-flight op and any pending response; no partial response is ever produced.
- Arbitration:
  - Round-robin search starts at rr pointer, scanning for the first set req_valid bit with wrap.
  - After a grant to index g, pointer = (g+1) mod NREQ.
  - Pointer does not move when there is no grant.
- Handshake:
  - req_ready[g]=1 only in IDLE, only for the selected g (combinational from state, pointer, req_valid).
  - Transfer occurs on a cycle where req_valid[g] && req_ready[g].
  - Requesters hold valid and data stable until accepted; valid may not be withdrawn.
- FSM:
  - IDLE: on a grant, register req_a/b/op[g] into alu_a/b/op, latch id=g, go to EXEC. With no valid requests, stay in IDLE.
  - EXEC (1 cycle): capture alu_z→rsp_z and alu_ov→rsp_ov; rsp_id=id; rsp_valid←1; go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On rsp_ready: rsp_valid←0, op_count+1, go to IDLE.
  - No new grant is issued in the RESP-exit cycle.
- Latency and throughput:
  - Accept at cycle T → rsp_valid at T+2.
  - Minimum 3 cycles per op (IDLE, EXEC, RESP with rsp_ready held high).
- Datapath:
  - alu_a/alu_b/alu_op hold their last value outside EXEC; there is no combinational path from req_* to alu_*.
  - Widths pass through unchanged; no sign extension or truncation.
- Boundaries:
  - All requesters valid: served strictly in order pointer, pointer+1, …
  - Single requester asserting continuously: served every 3 cycles.
  - op_count wraps 16'hFFFF→0.
  - A request arriving in EXEC/RESP waits; it is never dropped.

Decomposition:
- Shared package alu_pkg holds:
  - OPW and default nIO constants.
  - OP_MAX = 3'b010.
  - State enum {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], ptr, en.
  - Outputs grant one-hot and grant_idx.
  - Purely combinational; the pointer register lives in alu_rr_sched.

Test Plan:
- Single op, real ALU attached: req0 A=8'sd5, B=-8'sd3, op=3'b010, rsp_ready=1 → req_ready[0] at cycle 0; rsp_valid at cycle 2 with rsp_z=5, rsp_id=0, rsp_ov=0; op_count=1.
- All 4 valid from reset, each using op=010 with distinct A=i, B=-1 → grants in order 0,1,2,3; responses carry rsp_id 0,1,2,3 and rsp_z 0,1,2,3; 12 cycles total.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_* stable; no req_ready asserted; busy=1; the op completes after rsp_ready rises.
- Fairness: req1 and req3 held continuously for 20 ops → alternating ids 1,3,1,3…; neither starved.
- Reset mid-operation: rst_n low during EXEC → all outputs 0 immediately (async); after release, the next grant goes to index 0; no stale response.
- Wrap: op_count preloaded near wrap by running 65536 ops (or a forced value) → op_count wraps to 0 without affecting the handshake.
